// File: rtl/mem_arbiter.sv
// Round-robin arbiter that merges the instruction and data memory masters onto one
// shared memory port. The granted request is registered and held until the memory answers.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_address,
  input  logic              imem_action_stb,
  input  logic              imem_action_cyc,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_write,
  input  logic [MASK_W-1:0] dmem_byte_enable,
  input  logic              dmem_action_stb,
  input  logic              dmem_action_cyc,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              dmem_retry,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [MASK_W-1:0] mem_byte_enable,
  output logic              mem_action_stb,
  output logic              mem_action_cyc,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp,
  input  logic              mem_retry
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  typedef enum logic {LAST_I, LAST_D} master_t;

  state_t  state;
  master_t last_grant;

  logic imem_req;
  logic dmem_req;
  logic pick_dmem;

  assign imem_req  = imem_action_stb & imem_action_cyc;
  assign dmem_req  = dmem_action_stb & dmem_action_cyc;
  // dmem wins when it is alone or when imem was served last; ties alternate.
  assign pick_dmem = dmem_req & (~imem_req | (last_grant == LAST_I));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= LAST_I;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_action_stb  <= 1'b0;
      mem_action_cyc  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_dmem) begin
            state           <= GRANT_D;
            mem_address     <= dmem_address;
            mem_wdata       <= dmem_wdata;
            mem_write       <= dmem_write;
            mem_byte_enable <= dmem_byte_enable;
            mem_action_stb  <= 1'b1;
            mem_action_cyc  <= 1'b1;
          end else if (imem_req) begin
            state           <= GRANT_I;
            mem_address     <= imem_address;
            mem_wdata       <= '0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_action_stb  <= 1'b1;
            mem_action_cyc  <= 1'b1;
          end
        end
        GRANT_I, GRANT_D: begin
          // A retry leaves last_grant alone so the rejected master keeps priority.
          if (mem_resp) begin
            last_grant     <= (state == GRANT_D) ? LAST_D : LAST_I;
            state          <= IDLE;
            mem_action_stb <= 1'b0;
            mem_action_cyc <= 1'b0;
          end else if (mem_retry) begin
            state          <= IDLE;
            mem_action_stb <= 1'b0;
            mem_action_cyc <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Responses are gated by the master's cyc so an aborted access is silently dropped.
  assign imem_resp  = mem_resp & (state == GRANT_I) & imem_action_cyc;
  assign dmem_resp  = mem_resp & (state == GRANT_D) & dmem_action_cyc;
  assign dmem_retry = mem_retry & ~mem_resp & (state == GRANT_D) & dmem_action_cyc;

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule
